// File: rtl/amq_seq_dp.sv
// Multi-word add/subtract-modulus datapath with its own word sequencer and q-ROM addressing.
// Optional conditional-reduce restore pass is compiled in with `define AMQ_COND_REDUCE_EN.
module amq_seq_dp #(
  parameter int WORD_W = 118,
  parameter int NWORDS = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int QAW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              START,
  input  logic [1:0]        OP,
  input  logic [AW-1:0]     SRC_OFF,
  input  logic [AW-1:0]     DST_OFF,
  input  logic [QAW-1:0]    Q_BASE,
  output logic [QAW-1:0]    Q_ADDR,
  input  logic [WORD_W-1:0] Q_DATA,
  input  logic              LD_WE,
  input  logic [AW-1:0]     LD_ADDR,
  input  logic [WORD_W-1:0] LD_DATA,
  input  logic [AW-1:0]     RD_ADDR,
  output logic [WORD_W-1:0] RD_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              C_OUT
);

  localparam int HW = WORD_W / 2;
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
`ifdef AMQ_COND_REDUCE_EN
  localparam logic [1:0] S_RESTORE = 2'd3;
`endif

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] rf [DEPTH];
  logic [AW-1:0]     src_r, dst_r;
  logic [1:0]        op_r;
`ifdef AMQ_COND_REDUCE_EN
  logic [QAW-1:0]    q_base_r;
  logic              restore_go;
`endif
  logic              issue;
  logic              vld_p0;
  logic [WORD_W-1:0] x_p0;
  logic [CW-1:0]     idx_p0;
  logic              c_chain;
  logic              is_sub, is_copy, first_p0, last_p0, cin, res_c;
  logic [WORD_W-1:0] q_op, res_s;
  logic [WORD_W:0]   sum;

  // Carry-select adder: the upper half is precomputed for both incoming carries.
  function automatic logic [WORD_W:0] cs_add(input logic [WORD_W-1:0] a,
                                             input logic [WORD_W-1:0] b,
                                             input logic              ci);
    logic [HW:0] lo, hi0, hi1;
    lo  = {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]} + {{HW{1'b0}}, ci};
    hi0 = {1'b0, a[WORD_W-1:HW]} + {1'b0, b[WORD_W-1:HW]};
    hi1 = {1'b0, a[WORD_W-1:HW]} + {1'b0, b[WORD_W-1:HW]} + {{HW{1'b0}}, 1'b1};
    return lo[HW] ? {hi1, lo[HW-1:0]} : {hi0, lo[HW-1:0]};
  endfunction

  assign BUSY    = (state != S_IDLE);
  assign RD_DATA = rf[RD_ADDR];

`ifdef AMQ_COND_REDUCE_EN
  assign issue      = (state == S_RUN) || (state == S_RESTORE);
  assign restore_go = (op_r == 2'b10) && !res_c;
`else
  assign issue = (state == S_RUN);
`endif

  always_comb begin
    is_copy  = (op_r == 2'b11);
    is_sub   = (op_r == 2'b01) || (op_r == 2'b10);
    first_p0 = (idx_p0 == '0);
    last_p0  = (idx_p0 == CW'(NWORDS - 1));
    cin      = first_p0 ? is_sub : c_chain;
    q_op     = is_sub ? ~Q_DATA : Q_DATA;
    sum      = cs_add(x_p0, q_op, cin);
    res_s    = is_copy ? x_p0 : sum[WORD_W-1:0];
    res_c    = is_copy ? 1'b0 : sum[WORD_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      Q_ADDR <= '0;
      DONE   <= 1'b0;
      C_OUT  <= 1'b0;
      vld_p0 <= 1'b0;
    end else begin
      DONE   <= 1'b0;
      vld_p0 <= issue;
      if (vld_p0 && last_p0) C_OUT <= res_c;
      case (state)
        S_IDLE: begin
          if (START) begin
            state  <= S_RUN;
            cnt    <= '0;
            Q_ADDR <= Q_BASE;
          end
        end
        S_DRAIN: begin
`ifdef AMQ_COND_REDUCE_EN
          if (restore_go) begin
            state  <= S_RESTORE;
            Q_ADDR <= q_base_r;
          end else
`endif
          begin
            state <= S_IDLE;
            DONE  <= 1'b1;
          end
        end
        default: begin
          Q_ADDR <= Q_ADDR + QAW'(1);
          if (cnt == CW'(NWORDS - 1)) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // p0: operand word captured at issue; written back one cycle later.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && START) begin
      src_r <= SRC_OFF;
      dst_r <= DST_OFF;
      op_r  <= OP;
`ifdef AMQ_COND_REDUCE_EN
      q_base_r <= Q_BASE;
    end else if (state == S_DRAIN && restore_go) begin
      op_r <= 2'b11;
`endif
    end
    if (issue) begin
      x_p0   <= rf[src_r + AW'(cnt)];
      idx_p0 <= cnt;
    end
    if (vld_p0) begin
      c_chain                 <= res_c;
      rf[dst_r + AW'(idx_p0)] <= res_s;
    end else if (LD_WE && !BUSY) begin
      rf[LD_ADDR] <= LD_DATA;
    end
  end

endmodule

// File: tb/tb_amq_seq_dp.sv
// Directed bench for amq_seq_dp at WORD_W=16, NWORDS=2; q-ROM modelled as a 1-cycle synchronous memory.
module tb_amq_seq_dp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        START = 1'b0;
  logic [1:0]  OP = 2'b00;
  logic [3:0]  SRC_OFF = '0, DST_OFF = '0;
  logic [4:0]  Q_BASE = '0;
  logic [4:0]  Q_ADDR;
  logic [15:0] Q_DATA;
  logic        LD_WE = 1'b0;
  logic [3:0]  LD_ADDR = '0;
  logic [15:0] LD_DATA = '0;
  logic [3:0]  RD_ADDR = '0;
  logic [15:0] RD_DATA;
  logic        BUSY, DONE, C_OUT;

  logic [15:0] qrom [32];
  int          qa_log [32];
  int          busy_log [32];
  int          checks = 0;
  int          errors = 0;
  int          lat, dcnt, dlat;

  amq_seq_dp #(.WORD_W(16), .NWORDS(2), .DEPTH(16), .AW(4), .QAW(5)) dut (
    .clk(clk), .rst_n(rst_n), .START(START), .OP(OP), .SRC_OFF(SRC_OFF),
    .DST_OFF(DST_OFF), .Q_BASE(Q_BASE), .Q_ADDR(Q_ADDR), .Q_DATA(Q_DATA),
    .LD_WE(LD_WE), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .RD_ADDR(RD_ADDR),
    .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE), .C_OUT(C_OUT)
  );

  always #5 clk = ~clk;
  always @(posedge clk) Q_DATA <= qrom[Q_ADDR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ld(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    LD_WE = 1'b1; LD_ADDR = a; LD_DATA = d;
    @(negedge clk);
    LD_WE = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    RD_ADDR = a;
    #1;
    chk(tag, {16'h0, RD_DATA}, {16'h0, exp});
  endtask

  // Returns cycles from the START cycle to the DONE cycle (20 on timeout).
  task automatic run_op(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                        input logic [4:0] qb, input logic ld_en, input logic [3:0] la,
                        input logic [15:0] ldd, output int l);
    @(negedge clk);
    OP = op; SRC_OFF = src; DST_OFF = dst; Q_BASE = qb; START = 1'b1;
    LD_WE = ld_en; LD_ADDR = la; LD_DATA = ldd;
    l = 0;
    do begin
      @(negedge clk);
      START = 1'b0; LD_WE = 1'b0;
      l++;
      qa_log[l]   = int'(Q_ADDR);
      busy_log[l] = int'(BUSY);
    end while (!DONE && l < 20);
  endtask

  initial begin
    qrom = '{default: 16'h0};
    qrom[0] = 16'hFFFF; qrom[1] = 16'h0001; qrom[31] = 16'h0010;
    qrom[4] = 16'h0007; qrom[5] = 16'h0000;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_cout", {31'h0, C_OUT}, 32'h0);
    chk("rst_qaddr", {27'h0, Q_ADDR}, 32'h0);
    rst_n = 1'b1;

    // 1) add, two words with carry between them
    ld(4'd0, 16'h0003); ld(4'd1, 16'h0002);
    run_op(2'b00, 4'd0, 4'd2, 5'd0, 1'b0, 4'd0, 16'h0, lat);
    chk("add_lat", lat, 4);
    chk("add_busy_run", busy_log[1] + busy_log[2] + busy_log[3], 3);
    chk("add_busy_done", {31'h0, BUSY}, 32'h0);
    chk("add_cout", {31'h0, C_OUT}, 32'h0);
    rd_chk("add_w0", 4'd2, 16'h0002);
    rd_chk("add_w1", 4'd3, 16'h0004);

    // 2) subtract: equal operands, then zero minus q
    ld(4'd0, 16'hFFFF); ld(4'd1, 16'h0001);
    run_op(2'b01, 4'd0, 4'd4, 5'd0, 1'b0, 4'd0, 16'h0, lat);
    chk("sub_eq_cout", {31'h0, C_OUT}, 32'h1);
    rd_chk("sub_eq_w0", 4'd4, 16'h0000);
    rd_chk("sub_eq_w1", 4'd5, 16'h0000);
    ld(4'd0, 16'h0000); ld(4'd1, 16'h0000);
    run_op(2'b01, 4'd0, 4'd4, 5'd0, 1'b0, 4'd0, 16'h0, lat);
    chk("sub_neg_cout", {31'h0, C_OUT}, 32'h0);
    rd_chk("sub_neg_w0", 4'd4, 16'h0001);
    rd_chk("sub_neg_w1", 4'd5, 16'hFFFE);

    // 3) address wrap on source, destination and q-ROM
    ld(4'd15, 16'h1234); ld(4'd0, 16'h0003);
    run_op(2'b00, 4'd15, 4'd14, 5'd31, 1'b0, 4'd0, 16'h0, lat);
    chk("wrap_qa0", qa_log[1], 31);
    chk("wrap_qa1", qa_log[2], 0);
    chk("wrap_cout", {31'h0, C_OUT}, 32'h1);
    rd_chk("wrap_w0", 4'd14, 16'h1244);
    rd_chk("wrap_w1", 4'd15, 16'h0002);

    // 4) START and LD_WE while busy are ignored
    ld(4'd10, 16'h5555);
    @(negedge clk);
    OP = 2'b00; SRC_OFF = 4'd0; DST_OFF = 4'd6; Q_BASE = 5'd0; START = 1'b1;
    dcnt = 0; dlat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      START = (c == 1); LD_WE = (c == 1); LD_ADDR = 4'd10; LD_DATA = 16'hDEAD;
      if (DONE) begin dcnt++; dlat = c; end
    end
    chk("busy_done_cnt", dcnt, 1);
    chk("busy_done_lat", dlat, 4);
    rd_chk("busy_ld_ignored", 4'd10, 16'h5555);
    rd_chk("busy_w0", 4'd6, 16'h0002);
    rd_chk("busy_w1", 4'd7, 16'h0002);

    // 5) reset mid-operation, then a restart with a same-cycle load
    @(negedge clk);
    OP = 2'b00; SRC_OFF = 4'd0; DST_OFF = 4'd12; Q_BASE = 5'd0; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, BUSY}, 32'h0);
    chk("abort_done", {31'h0, DONE}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (DONE) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(2'b00, 4'd0, 4'd8, 5'd0, 1'b1, 4'd0, 16'h0100, lat);
    chk("restart_lat", lat, 4);
    rd_chk("restart_w0", 4'd8, 16'h00FF);
    rd_chk("restart_w1", 4'd9, 16'h0002);

    // 6) OP=10 with X<q, then X>=q
    ld(4'd0, 16'h0005); ld(4'd1, 16'h0000);
    run_op(2'b10, 4'd0, 4'd4, 5'd4, 1'b0, 4'd0, 16'h0, lat);
`ifdef AMQ_COND_REDUCE_EN
    chk("cond_lt_lat", lat, 7);
    chk("cond_lt_cout", {31'h0, C_OUT}, 32'h0);
    rd_chk("cond_lt_w0", 4'd4, 16'h0005);
    rd_chk("cond_lt_w1", 4'd5, 16'h0000);
`else
    chk("cond_lt_lat", lat, 4);
    chk("cond_lt_cout", {31'h0, C_OUT}, 32'h0);
    rd_chk("cond_lt_w0", 4'd4, 16'hFFFE);
    rd_chk("cond_lt_w1", 4'd5, 16'hFFFF);
`endif
    ld(4'd0, 16'h0009);
    run_op(2'b10, 4'd0, 4'd4, 5'd4, 1'b0, 4'd0, 16'h0, lat);
    chk("cond_ge_lat", lat, 4);
    chk("cond_ge_cout", {31'h0, C_OUT}, 32'h1);
    rd_chk("cond_ge_w0", 4'd4, 16'h0002);
    rd_chk("cond_ge_w1", 4'd5, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
